stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised, registered N-channel stream multiplexer with valid/ready handshaking on every input and on the output. It selects one input beat per cycle, either by an external select (successor to the plain combinational 4:1 mux) or by round-robin arbitration, and holds it in an output register until the consumer accepts it. It sits between multiple producers (register-file read ports, ALU result paths, memory responses) and a single shared consumer in the 32-bit datapath.

## Interface
- WIDTH, 32, data width per channel in bits
- NCH, 4, number of input channels (2..16)
- MODE, 0, 0 = external select via `sel`, 1 = round-robin arbitration (`sel` ignored)
- SELW (localparam), $clog2(NCH), channel-index width

- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- in_data  input  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel beat available
- in_ready  output  NCH  per-channel beat accepted this cycle (at most one bit set)
- sel  input  SELW  channel select, MODE 0 only
- out_data  output  WIDTH  registered beat
- out_valid  output  1  out_data holds an unconsumed beat
- out_ready  input  1  consumer accepts beat
- out_chan  output  SELW  source channel of out_data

## Operation
- load_en = !out_valid || out_ready (register empty or draining this cycle).
- Grant g (combinational):
  - MODE 0: g = sel. If sel >= NCH, no grant.
  - MODE 1: first channel c with in_valid[c]=1, searching ptr, ptr+1, ... wrapping mod NCH. No valid channel → no grant.
- in_ready[c] = load_en && grant exists && c == g; all other bits 0. In MODE 1 in_ready depends combinationally on in_valid; in MODE 0 it does not.
- Transfer on channel g when in_valid[g] && in_ready[g]: next edge out_data ← in_data[g], out_chan ← g, out_valid ← 1.
- load_en with no transfer: out_valid ← 0; out_data and out_chan hold last values.
- !load_en (out_valid && !out_ready): out_data, out_chan, out_valid hold; all in_ready 0.
- Round-robin pointer ptr (SELW bits, MODE 1 only): on transfer from g, ptr ← (g+1) mod NCH (wraps NCH-1 → 0, correct for non-power-of-2 NCH). Unchanged otherwise. A channel holding in_valid waits at most NCH-1 transfers.
- MODE 0 has no fairness; sel changes take effect the same cycle.

## Timing
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_chan=0, ptr=0. During rst, in_ready all 0. Beat in the output register is discarded; no input is accepted in a reset cycle.
- Latency: input transfer at edge N → out_valid=1 with that data after edge N (one cycle).
- Throughput: one beat per cycle with out_ready held 1 and an input valid.
- Simultaneous drain and load (out_valid && out_ready && transfer): old beat consumed and new beat loaded on the same edge; out_valid stays 1, no bubble.
- Output stable: while out_valid && !out_ready, out_data and out_chan must not change.
- Producers may deassert in_valid only after a transfer; the block does not require it (no beat is taken without in_ready).

## Test plan
- Reset: drive all in_valid=1, rst=1 for 2 cycles → in_ready=0000, out_valid=0, out_data=0, out_chan=0; first post-reset transfer in MODE 1 comes from channel 0.
- MODE 0 select sweep (NCH=4, WIDTH=32): in_data = {0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, all valid, out_ready=1, sel=0,1,2,3 → next-cycle out_data = 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003, out_chan = sel.
- MODE 1 fairness: all four channels continuously valid, out_ready=1 → out_chan sequence 0,1,2,3,0,1,… one beat per cycle, out_valid constant 1.
- MODE 1 skip/wrap: only channels 1 and 3 valid, ptr=2 → grant 3, then 1, then 3; channel 0 and 2 in_ready stay 0.
- Backpressure: out_ready=0 for 5 cycles with beat 0xBBBB0001 held → out_data/out_chan unchanged, all in_ready 0; raise out_ready → next beat loads same edge, no bubble.
- Mid-operation reset and out-of-range select: NCH=3, MODE 0, sel=3 → in_ready=000, out_valid falls to 0 after drain; assert rst with out_valid=1 → out_valid=0 next cycle, beat lost.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-channel valid/ready stream mux with external-select or round-robin grant
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int NCH = 4,
  parameter int MODE = 0,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic [SELW-1:0]        sel,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SELW-1:0]        out_chan
);
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d, ptr_q, ptr_d, grant;
  logic             out_valid_q, out_valid_d, has_grant, load_en, xfer;
  int               idx;
  assign load_en = !out_valid_q || out_ready;
  assign xfer = !rst && load_en && has_grant && in_valid[grant];
  assign in_ready = (!rst && load_en && has_grant) ? NCH'(1) << grant : '0;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan = out_chan_q;
  // grant: external select (out-of-range means none) or first valid channel at or after ptr
  always_comb begin
    idx = 0;
    grant = sel;
    has_grant = 32'(sel) < NCH;
    if (MODE != 0) begin
      grant = '0;
      has_grant = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
        idx = (int'(ptr_q) + i) % NCH;
        if (in_valid[idx]) begin
          grant = SELW'(idx);
          has_grant = 1'b1;
        end
      end
    end
  end
  // next output register contents and round-robin pointer (explicit wrap for non-power-of-2 NCH)
  always_comb begin
    out_valid_d = xfer || (out_valid_q && !load_en);
    out_data_d = xfer ? in_data[grant*WIDTH +: WIDTH] : out_data_q;
    out_chan_d = xfer ? grant : out_chan_q;
    ptr_d = xfer ? ((32'(grant) == NCH - 1) ? '0 : grant + SELW'(1)) : ptr_q;
  end
  // state registers; reset discards any held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for a 4-channel round-robin and a 3-channel external-select mux
module tb_stream_mux_rr;
  localparam int W = 32;
  typedef struct packed {logic [W-1:0] d; logic [1:0] c;} beat_t;
  logic clk = 1'b0;
  logic rst;
  logic [4*W-1:0] a_in_data;
  logic [3:0] a_in_valid, a_in_ready;
  logic [1:0] a_sel, a_out_chan;
  logic [W-1:0] a_out_data;
  logic a_out_valid, a_out_ready;
  logic [3*W-1:0] b_in_data;
  logic [2:0] b_in_valid, b_in_ready;
  logic [1:0] b_sel, b_out_chan;
  logic [W-1:0] b_out_data;
  logic b_out_valid, b_out_ready;
  int tests = 0, fails = 0;
  beat_t qa[$], qb[$];
  int a_ptr = 0;
  bit a_full = 0, b_full = 0;
  always #5 clk = ~clk;
  stream_mux_rr #(.WIDTH(W), .NCH(4), .MODE(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sel(a_sel), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_chan(a_out_chan));
  stream_mux_rr #(.WIDTH(W), .NCH(3), .MODE(0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chan(b_out_chan));
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic rand_data();
    for (int c = 0; c < 4; c++) a_in_data[c*W +: W] = $urandom;
    for (int c = 0; c < 3; c++) b_in_data[c*W +: W] = $urandom;
  endtask
  // reference model: checks grants for this cycle and queues the beat the coming edge should load
  task automatic step();
    int ga, gb;
    bit la, lb;
    #1;
    la = !rst && (!a_full || a_out_ready);
    ga = -1;
    if (la) for (int k = 0; k < 4; k++) if (ga < 0 && a_in_valid[(a_ptr + k) % 4]) ga = (a_ptr + k) % 4;
    chk("a_in_ready", a_in_ready, ga < 0 ? 0 : (1 << ga));
    chk("a_out_valid", a_out_valid, a_full);
    if (rst) begin
      a_full = 0; a_ptr = 0; qa.delete();
    end else if (ga >= 0) begin
      qa.push_back({a_in_data[ga*W +: W], 2'(ga)}); a_full = 1; a_ptr = (ga + 1) % 4;
    end else if (la) a_full = 0;
    lb = !rst && (!b_full || b_out_ready);
    gb = (lb && b_sel < 3) ? int'(b_sel) : -1;
    chk("b_in_ready", b_in_ready, gb < 0 ? 0 : (1 << gb));
    chk("b_out_valid", b_out_valid, b_full);
    if (rst) begin
      b_full = 0; qb.delete();
    end else if (gb >= 0 && b_in_valid[gb]) begin
      qb.push_back({b_in_data[gb*W +: W], 2'(gb)}); b_full = 1;
    end else if (lb) b_full = 0;
  endtask
  // monitor: every accepted output beat must match the oldest expected beat
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_beat_unexpected", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_out_data", a_out_data, e.d);
          chk("a_out_chan", a_out_chan, e.c);
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_beat_unexpected", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_out_data", b_out_data, e.d);
          chk("b_out_chan", b_out_chan, e.c);
        end
      end
    end
  end
  initial begin
    rst = 1; a_out_ready = 0; b_out_ready = 0; a_in_valid = '1; b_in_valid = '1; a_sel = 0; b_sel = 0;
    rand_data();
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    rst = 0;
    chk("a_rst_data", a_out_data, 0);
    chk("a_rst_chan", a_out_chan, 0);
    chk("b_rst_data", b_out_data, 0);
    chk("b_rst_chan", b_out_chan, 0);
    a_out_ready = 1; b_out_ready = 1;
    b_in_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    step();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rand_data(); a_in_valid = '1; a_out_ready = 1;
      b_in_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}; b_in_valid = '1; b_sel = 2'(i % 3); b_out_ready = 1;
      step();
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rand_data(); a_in_valid = 4'b1010;
      step();
    end
    @(negedge clk);
    a_in_valid = '1; b_sel = 1; b_in_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rand_data(); a_out_ready = 0; b_out_ready = 0; b_sel = 2'(i % 3);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_data(); a_out_ready = 1; b_out_ready = 1;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_data(); b_sel = 3;
      step();
    end
    @(negedge clk);
    b_sel = 0;
    step();
    @(negedge clk);
    rst = 1; a_out_ready = 0; b_out_ready = 0;
    step();
    @(negedge clk);
    rst = 0; a_in_valid = '0; b_in_valid = '0;
    step();
    repeat (400) begin
      @(negedge clk);
      rst = ($urandom_range(39) == 0);
      rand_data();
      a_in_valid = 4'($urandom); b_in_valid = 3'($urandom); b_sel = 2'($urandom);
      a_out_ready = !rst && ($urandom_range(3) != 0);
      b_out_ready = !rst && ($urandom_range(3) != 0);
      step();
    end
    repeat (4) begin
      @(negedge clk);
      rst = 0; a_in_valid = '0; b_in_valid = '0; a_out_ready = 1; b_out_ready = 1;
      step();
    end
    @(negedge clk);
    #3;
    chk("a_beats_left", qa.size(), 0);
    chk("b_beats_left", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
